// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        LD_STALL = 2'd2
    } state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int DEF_REG_ADDR_WIDTH = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with boot hold and perf counters
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int REG_ADDR_WIDTH    = DEF_REG_ADDR_WIDTH,
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int BOOT_CYCLES       = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic                      id_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rd_addr,
    input  logic                      idex_is_load,
    input  logic                      idex_reg_wen,
    input  logic                      ex_pc_write,
    input  logic                      mem_busy,
    input  logic                      cnt_clear,
    output logic                      pc_en,
    output logic                      pc_sel_branch,
    output logic                      ifid_en,
    output logic                      ifid_flush,
    output logic                      idex_en,
    output logic                      idex_flush,
    output logic                      exmem_en,
    output logic                      memwb_en,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);
    state_t     state, state_nxt;
    logic [2:0] boot_ctr, boot_nxt;
    logic [1:0] ld_ctr, ld_nxt;
    logic       load_use, stall_inc, flush_inc;

    // No R0 exclusion: a load to R0 still stalls a consumer of R0.
    assign load_use = idex_is_load && idex_reg_wen &&
                      ((id_rs1_used && id_rs1_addr == idex_rd_addr) ||
                       (id_rs2_used && id_rs2_addr == idex_rd_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_ctr <= 3'(BOOT_CYCLES - 1);
            ld_ctr   <= '0;
        end else begin
            state    <= state_nxt;
            boot_ctr <= boot_nxt;
            ld_ctr   <= ld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        boot_nxt  = boot_ctr;
        ld_nxt    = ld_ctr;
        if (state == BOOT) begin
            boot_nxt  = (boot_ctr == '0) ? boot_ctr : boot_ctr - 1'b1;
            state_nxt = (boot_ctr == '0) ? RUN : BOOT;
        end else if (!mem_busy) begin
            state_nxt = (state == LD_STALL) ? LD_STALL : RUN;
            if (ex_pc_write) begin
                state_nxt = RUN;
            end else if (state == LD_STALL) begin
                ld_nxt    = ld_ctr - 1'b1;
                state_nxt = (ld_ctr == '0) ? RUN : LD_STALL;
            end else if (load_use && LOAD_STALL_CYCLES > 1) begin
                ld_nxt    = 2'(LOAD_STALL_CYCLES - 2);
                state_nxt = LD_STALL;
            end
        end
    end

    // mem_busy freezes everything, so a redirect held in EX is taken once busy drops.
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        if (state == BOOT) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_pc_write) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (state == LD_STALL || load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall_inc = (state != BOOT) && !pc_en;
    assign flush_inc = (state != BOOT) && !mem_busy && ex_pc_write;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clear),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (cnt_clear),
        .count (flush_cnt)
    );
endmodule
